// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, flushes, forwarding, memory wait sequencing
module hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             mem_read_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    input  logic             branch_taken_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             fstall,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    typedef enum logic [1:0] {RUN, DWAIT, IWAIT} state_t;

    localparam logic [16:0] TIMEOUT = 17'(DMEM_TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        dmem_wait;
    logic        load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] m, input logic wm,
                                           input logic [4:0] w, input logic ww);
        if (wm && m != 5'd0 && m == r)
            return 2'd2;
        else if (ww && w != 5'd0 && w == r)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    assign dmem_wait = (state == DWAIT) || (dmem_req_m && !dmem_ready);
    assign load_use  = mem_read_e && (rd_e != 5'd0) &&
                       ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));

    always_comb begin
        fstall  = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a_e = 2'd0;
        fwd_b_e = 2'd0;
        if (!rstn) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            fwd_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
            fwd_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
            if (dmem_wait) begin
                fstall  = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                if (load_use) begin
                    fstall  = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                // A held F/D register must not also be bubbled.
                if (!imem_ready) begin
                    fstall  = 1'b1;
                    flush_d = !load_use;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN, IWAIT: begin
                if (dmem_req_m && !dmem_ready)
                    state_nxt = DWAIT;
                else if (!imem_ready)
                    state_nxt = IWAIT;
                else
                    state_nxt = RUN;
            end
            DWAIT:   state_nxt = dmem_ready ? RUN : DWAIT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, fstall};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, branch_taken_e && !dmem_wait};
            if (state == DWAIT) begin
                if ({1'b0, wait_cnt} + 17'd1 >= TIMEOUT)
                    err_timeout <= 1'b1;
                if (dmem_ready)
                    wait_cnt <= 16'd0;
                else if (wait_cnt != 16'hFFFF)
                    wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl with per-cycle behavioural model
module tb_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rstn;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic rs1_used_d, rs2_used_d, mem_read_e, reg_write_m, reg_write_w;
    logic branch_taken_e, dmem_req_m, dmem_ready, imem_ready;
    logic fstall, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, err_timeout;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int passes = 0;

    bit     m_dwait;
    int     m_run;
    bit     m_err;
    longint m_stalls, m_flushes;

    always #5 clk = ~clk;

    hazard_ctrl #(.DMEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .mem_read_e(mem_read_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .branch_taken_e(branch_taken_e), .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .fstall(fstall), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_fwd(int r);
        if (reg_write_m && rd_m != 0 && int'(rd_m) == r) return 2;
        if (reg_write_w && rd_w != 0 && int'(rd_w) == r) return 1;
        return 0;
    endfunction

    // Expected controls {fstall,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}
    function automatic logic [6:0] m_ctrl();
        bit mw, lu, hold, bub_d, bub_e;
        if (!rstn) return 7'b0000111;
        mw = m_dwait || (dmem_req_m && !dmem_ready);
        if (mw) return 7'b1111001;
        if (branch_taken_e) return 7'b0000110;
        lu = mem_read_e && rd_e != 0 &&
             ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
        hold  = lu || !imem_ready;
        bub_e = lu;
        bub_d = !imem_ready && !lu;
        return {hold, lu, 2'b00, bub_d, bub_e, 1'b0};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_dwait = 0; m_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            logic [6:0] c;
            bit mw;
            c  = m_ctrl();
            mw = m_dwait || (dmem_req_m && !dmem_ready);
            m_stalls  = (m_stalls + longint'(c[6])) % (64'd1 << 32);
            m_flushes = (m_flushes + longint'(branch_taken_e && !mw)) % (64'd1 << 32);
            if (m_dwait) begin
                m_run++;
                if (m_run >= TO) m_err = 1;
            end
            m_dwait = m_dwait ? !dmem_ready : (dmem_req_m && !dmem_ready);
            if (!m_dwait) m_run = 0;
        end
    end

    always @(negedge clk) begin
        logic [6:0] c;
        c = m_ctrl();
        check("cyc_fstall",  fstall,  c[6]);
        check("cyc_stall_d", stall_d, c[5]);
        check("cyc_stall_e", stall_e, c[4]);
        check("cyc_stall_m", stall_m, c[3]);
        check("cyc_flush_d", flush_d, c[2]);
        check("cyc_flush_e", flush_e, c[1]);
        check("cyc_flush_w", flush_w, c[0]);
        check("cyc_fwd_a",   fwd_a_e, rstn ? m_fwd(int'(rs1_e)) : 0);
        check("cyc_fwd_b",   fwd_b_e, rstn ? m_fwd(int'(rs2_e)) : 0);
        check("cyc_stall_cnt", stall_cnt, m_stalls);
        check("cyc_flush_cnt", flush_cnt, m_flushes);
        check("cyc_err",       err_timeout, m_err);
    end

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; mem_read_e = 0;
        rd_m = 0; reg_write_m = 0; rd_w = 0; reg_write_w = 0;
        branch_taken_e = 0; dmem_req_m = 0; dmem_ready = 1; imem_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        rd_e = 5; mem_read_e = 1; rs1_d = 5; rs1_used_d = 1;
    endtask

    initial begin
        idle();
        rstn = 0;
        #12;
        check("rst_flush_d", flush_d, 1);
        check("rst_flush_w", flush_w, 1);
        check("rst_fstall", fstall, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rstn = 1;
        tick();

        set_load_use();
        #2;
        check("lu_fstall", fstall, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        tick();
        mem_read_e = 0;
        #2;
        check("lu_off_fstall", fstall, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        tick();

        set_load_use();
        branch_taken_e = 1;
        #2;
        check("br_flush_d", flush_d, 1);
        check("br_flush_e", flush_e, 1);
        check("br_fstall", fstall, 0);
        tick();
        idle();
        #2;
        check("br_flush_cnt", flush_cnt, 1);

        tick();
        dmem_req_m = 1; dmem_ready = 0; branch_taken_e = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("dw_stall_m", stall_m, 1);
            check("dw_flush_e", flush_e, 0);
            tick();
        end
        dmem_ready = 1;
        #2;
        check("dw_last_stall_m", stall_m, 1);
        check("dw_last_flush_w", flush_w, 1);
        tick();
        dmem_req_m = 0;
        #2;
        check("dw_rel_stall_m", stall_m, 0);
        check("dw_rel_flush_e", flush_e, 1);
        tick();
        idle();
        #2;
        check("dw_stall_cnt", stall_cnt, 5);
        check("dw_flush_cnt", flush_cnt, 2);
        check("dw_no_err", err_timeout, 0);

        tick();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        check("to_err_pre", err_timeout, 0);
        tick();
        check("to_err_set", err_timeout, 1);
        tick();
        dmem_ready = 1;
        tick();
        idle();
        #2;
        check("to_err_sticky", err_timeout, 1);
        check("to_released", stall_m, 0);
        tick();

        imem_ready = 0;
        #2;
        check("im_fstall", fstall, 1);
        check("im_flush_d", flush_d, 1);
        set_load_use();
        #1;
        check("im_lu_flush_d", flush_d, 0);
        check("im_lu_flush_e", flush_e, 1);
        check("im_lu_stall_d", stall_d, 1);
        tick();
        idle();

        rs1_e = 3; rs2_e = 3; rd_m = 3; reg_write_m = 1; rd_w = 3; reg_write_w = 1;
        #2;
        check("fwd_a_m", fwd_a_e, 2);
        check("fwd_b_m", fwd_b_e, 2);
        tick();
        rd_m = 0;
        #2;
        check("fwd_a_w", fwd_a_e, 1);
        check("fwd_b_w", fwd_b_e, 1);
        tick();
        rd_w = 0;
        #2;
        check("fwd_a_rf", fwd_a_e, 0);
        check("fwd_b_rf", fwd_b_e, 0);
        tick();
        idle();

        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rstn = 0;
        #1;
        check("ar_stall_cnt", stall_cnt, 0);
        check("ar_err", err_timeout, 0);
        check("ar_flush_d", flush_d, 1);
        check("ar_flush_w", flush_w, 1);
        check("ar_stall_m", stall_m, 0);
        idle();
        #9;
        rstn = 1;
        tick();
        #2;
        check("ar_post_fstall", fstall, 0);
        check("ar_post_stall_m", stall_m, 0);
        check("ar_post_flush_d", flush_d, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Generates per-stage stall and flush controls, the `fstall` input of the PC update logic, and E-stage forwarding selects.
- Sequences multi-cycle data-memory and instruction-memory waits with a small FSM.
- Keeps stall/flush performance counters and a sticky timeout error.

Parameters:
- DMEM_TIMEOUT, 255, max consecutive dmem wait cycles before err_timeout sets (1..65535)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- rs1_d  in  5  D-stage source register 1
- rs2_d  in  5  D-stage source register 2
- rs1_used_d  in  1  D-stage instruction reads rs1
- rs2_used_d  in  1  D-stage instruction reads rs2
- rs1_e  in  5  E-stage source register 1
- rs2_e  in  5  E-stage source register 2
- rd_e  in  5  E-stage destination register
- mem_read_e  in  1  E-stage instruction is a load
- rd_m  in  5  M-stage destination register
- reg_write_m  in  1  M-stage writes register file
- rd_w  in  5  W-stage destination register
- reg_write_w  in  1  W-stage writes register file
- branch_taken_e  in  1  E-stage redirect (PC logic flush)
- dmem_req_m  in  1  M-stage memory access active
- dmem_ready  in  1  data memory completes access this cycle
- imem_ready  in  1  instruction fetch data valid this cycle
- fstall  out  1  hold PC (to PC update logic)
- stall_d  out  1  hold F/D register
- stall_e  out  1  hold D/E register
- stall_m  out  1  hold E/M register
- flush_d  out  1  load bubble into F/D
- flush_e  out  1  load bubble into D/E
- flush_w  out  1  load bubble into M/W
- fwd_a_e  out  2  E operand A select: 0 regfile, 1 from W, 2 from M
- fwd_b_e  out  2  same for operand B
- stall_cnt  out  CNT_W  cycles with fstall=1
- flush_cnt  out  CNT_W  cycles with flush_e=1 due to branch
- err_timeout  out  1  sticky dmem timeout flag

Behaviour:
- Reset (rstn low, asynchronous, any state):
  - state=RUN; wait counter=0; stall_cnt=0, flush_cnt=0, err_timeout=0.
  - Combinational outputs while rstn low: all stalls 0, flush_d=1, flush_e=1, flush_w=1, fwd=0.
  - Reset mid-wait aborts the wait; there is no residual stall after release.
- FSM states: RUN, DWAIT, IWAIT.
  - RUN→DWAIT: dmem_req_m=1 and dmem_ready=0.
  - DWAIT→RUN: dmem_ready=1.
  - RUN→IWAIT: imem_ready=0 and no dmem wait pending. DWAIT has priority over IWAIT.
  - IWAIT→RUN: imem_ready=1.
  - IWAIT→DWAIT: dmem_req_m=1 and dmem_ready=0.
- Priority, highest first. Evaluation is combinational on the current state plus inputs.
  1. Dmem wait: DWAIT, or RUN with dmem_req_m & !dmem_ready. Outputs fstall=stall_d=stall_e=stall_m=1 and flush_w=1. Branch and load-use are frozen, not acted upon.
  2. Branch: branch_taken_e=1. Outputs flush_d=1, flush_e=1, no stalls. Overrides load-use and imem wait, because the fetched and decoded instructions are discarded.
  3. Load-use: mem_read_e & rd_e!=0 & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)). Outputs fstall=stall_d=1, flush_e=1.
  4. Imem wait: imem_ready=0. Outputs fstall=1, flush_d=1.
  - Otherwise all controls are 0.
- Load-use and imem wait may coincide. Result: fstall=stall_d=1, flush_e=1, flush_d=0 (stall_d dominates flush_d).
- Forwarding, per operand, for the E-stage register (rs1_e or rs2_e):
  - Select 2 if reg_write_m & rd_m!=0 & rd_m==reg.
  - Else select 1 if reg_write_w & rd_w!=0 & rd_w==reg.
  - Else select 0.
  - Forwarding is independent of stalls.
- Wait counter:
  - Increments each DWAIT cycle and clears on leaving DWAIT.
  - Reaching DMEM_TIMEOUT sets err_timeout=1, which stays set until reset.
  - The FSM keeps waiting after a timeout.
- Counters:
  - stall_cnt increments on each clock edge with fstall=1.
  - flush_cnt increments on each edge with branch_taken_e=1 and no dmem wait.
  - Both wrap modulo 2^CNT_W.
- Latency: controls are same-cycle combinational; state, counters and error update on the next rising edge.

Test Plan:
- **Load-use:** rd_e=5, mem_read_e=1, rs1_d=5, rs1_used_d=1 → same cycle fstall=1, stall_d=1, flush_e=1. Next cycle mem_read_e=0 → all 0; stall_cnt=1.
- **Branch over load-use:** branch_taken_e=1 with the load-use condition above → flush_d=flush_e=1, fstall=0; flush_cnt increments by 1.
- **Dmem wait:** dmem_req_m=1, dmem_ready=0 for 3 cycles, then 1 → stalls 1 for 4 cycles with flush_w=1, state returns to RUN. A branch_taken_e held during the wait is acted on only after release.
- **Timeout:** DMEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles → err_timeout=1 after the 4th DWAIT edge and stays 1 after dmem_ready=1; clears only on rstn low.
- **Forwarding:** rs1_e=rs2_e=3, rd_m=3, reg_write_m=1, rd_w=3, reg_write_w=1 → fwd_a_e=fwd_b_e=2. With rd_m=0 → both 1. With rd_w=0 as well → both 0.
- **Async reset:** rstn low mid-DWAIT, asynchronous to clk → counters and err_timeout 0 immediately, flush_d/e/w=1, stalls 0. After release with ready inputs high → RUN, all controls 0.
